// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int WD_W = 8;

  // Replicated to the data width to build the all-ones timeout read data.
  localparam logic TMO_FILL = 1'b1;

endpackage

// File: rtl/mem_port_watchdog.sv
// BUSY-cycle watchdog: cleared on grant, counts cycles without mem_ack and
// flags expiry on the cycle whose increment would reach TMO.
module mem_port_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WD_W-1:0] TMO_LAST = WD_W'(TMO - 1);

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == TMO_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and M-stage ports onto one single-port memory, with
// fixed data priority, a watchdog abort and combinational pipeline stalls.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          err
);

  localparam logic [DW-1:0] TMO_RDATA = {DW{TMO_FILL}};

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          err_q, err_d;
  logic          wd_clr, wd_en, wd_expired;

  mem_port_watchdog #(
    .TMO (TMO)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  assign wd_en = (state_q == BUSY) && !mem_ack;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    wd_clr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Data wins a tie: it belongs to the older instruction.
        if (d_req) begin
          owner_d     = OWN_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          state_d     = BUSY;
          wd_clr      = 1'b1;
        end else if (if_req) begin
          owner_d     = OWN_IF;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          state_d     = BUSY;
          wd_clr      = 1'b1;
        end
      end
      BUSY: begin
        // An ack on the expiry edge takes precedence over the abort.
        if (mem_ack) begin
          if (owner_q == OWN_D) d_rdata_d = mem_rdata;
          else                  if_rdata_d = mem_rdata;
          state_d = RESP;
        end else if (wd_expired) begin
          if (owner_q == OWN_D) d_rdata_d = TMO_RDATA;
          else                  if_rdata_d = TMO_RDATA;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  // Decoded from state so reset drops the strobe without waiting for a clock.
  assign mem_en    = (state_q == BUSY);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = (state_q == RESP) && (owner_q == OWN_IF);
  assign d_ready   = (state_q == RESP) && (owner_q == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign stall_if  = if_req && !if_ready;
  assign stall_mem = d_req && !d_ready;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: DW, 32, data width of all data buses.
REQ-002 Parameter: AW, 32, address width of all address buses.
REQ-003 Parameter: TMO, 15, maximum BUSY cycles allowed while waiting for mem_ack before abort; legal range 1..255.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: if_req  in  1  fetch request; held with if_addr until if_ready.
REQ-008 Port: if_addr  in  AW  fetch address.
REQ-009 Port: if_rdata  out  DW  fetch read data; valid when if_ready=1.
REQ-010 Port: if_ready  out  1  one-cycle fetch completion pulse.
REQ-011 Port: d_req  in  1  M-stage load/store request; held with d_we, d_addr and d_wdata until d_ready.
REQ-012 Port: d_we  in  1  1 = store, 0 = load.
REQ-013 Port: d_addr  in  AW  data address.
REQ-014 Port: d_wdata  in  DW  store data.
REQ-015 Port: d_rdata  out  DW  load data; valid when d_ready=1.
REQ-016 Port: d_ready  out  1  one-cycle data completion pulse.
REQ-017 Port: mem_en  out  1  shared single-port memory access strobe.
REQ-018 Port: mem_we  out  1  memory write enable.
REQ-019 Port: mem_addr  out  AW  memory address.
REQ-020 Port: mem_wdata  out  DW  memory write data.
REQ-021 Port: mem_rdata  in  DW  memory read data; valid with mem_ack.
REQ-022 Port: mem_ack  in  1  memory completion; variable latency, at least 1 cycle after mem_en rises.
REQ-023 Port: stall_if  out  1  to hazard unit; forces StallF/StallD.
REQ-024 Port: stall_mem  out  1  to hazard unit; freezes F, D, E and M, and bubbles W.
REQ-025 Port: err  out  1  sticky timeout flag.

Function
REQ-026 The FSM SHALL have exactly three states:
- IDLE: no access in progress.
- BUSY: memory access in progress.
- RESP: one-cycle completion state.
REQ-027 In IDLE, grant rules SHALL be:
- d_req=1: grant data (fixed priority; the older instruction wins), regardless of if_req.
- else if_req=1: grant fetch.
- else stay in IDLE.
REQ-028 On grant, the arbiter SHALL register owner, mem_we (0 for fetch, d_we for data), mem_addr and mem_wdata, and SHALL enter BUSY with mem_en=1 from the next cycle.
REQ-029 mem_we, mem_addr and mem_wdata SHALL stay stable for the whole BUSY state, independent of later requester inputs.
REQ-030 In BUSY, when mem_ack=1 at an edge, the arbiter SHALL capture mem_rdata into the owner's rdata register, deassert mem_en and enter RESP.
REQ-031 In RESP, the owner's ready SHALL be 1 for exactly that cycle, and no new grant SHALL be made; RESP SHALL always go to IDLE.
REQ-032 mem_ack outside BUSY SHALL be ignored.
REQ-033 if_rdata and d_rdata SHALL hold their last captured value until the next capture; the non-owner register SHALL be untouched.
REQ-034 For stores, d_rdata SHALL also be updated from mem_rdata.
REQ-035 Minimum latency SHALL be req sampled at edge 0, mem_en in cycle 1, mem_ack at edge 1, ready in cycle 2, IDLE in cycle 3.
REQ-036 stall_if SHALL equal if_req AND NOT if_ready.
REQ-037 stall_mem SHALL equal d_req AND NOT d_ready.
REQ-038 stall_if and stall_mem SHALL both be purely combinational.
REQ-039 A 8-bit watchdog counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ack.
REQ-040 If the watchdog reaches TMO, the arbiter SHALL:
- enter RESP with the owner's ready=1 and its rdata forced to all-ones;
- set err=1.
REQ-041 err SHALL clear only by reset.
REQ-042 When mem_ack and the timeout occur at the same edge, mem_ack SHALL win and err SHALL stay unchanged.
REQ-043 When both requests arrive in the same cycle, data SHALL be served first and fetch SHALL be granted at the IDLE that follows data's RESP; stall_if SHALL stay high throughout.
REQ-044 A request that drops before its grant SHALL be treated as never issued.

Reset
REQ-045 rst_n=0 SHALL asynchronously force:
- state to IDLE; mem_en, mem_we, if_ready, d_ready and err to 0;
- mem_addr, mem_wdata, if_rdata and d_rdata to 0; watchdog to 0.
REQ-046 Reset during BUSY SHALL abort the access immediately (mem_en=0 without waiting for a clock), and no ready pulse SHALL follow reset release.
REQ-047 The first grant after reset SHALL be made at the first rising edge with rst_n=1 and a request present.

Structure
REQ-048 The shared package SHALL hold:
- the state encoding (IDLE=2'b00, BUSY=2'b01, RESP=2'b10);
- the owner encoding (OWN_IF=0, OWN_D=1);
- the timeout rdata constant (all-ones).
REQ-049 The watchdog SHALL be one sub-module, mem_port_watchdog (clear, enable, TMO compare, expired output); all other logic SHALL sit in mem_port_arbiter.

Verification
REQ-050 Fetch only: if_req=1, if_addr=0x00400000, mem_ack one cycle after mem_en, mem_rdata=0x8C010004 -> mem_en in cycle 1; if_ready and if_rdata=0x8C010004 in cycle 2; stall_if=1 in cycles 0-1.
REQ-051 Collision: if_req and d_req (d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF) together -> first mem_addr=0x10010000 with mem_we=1; fetch granted after d_ready; stall_if=1 until if_ready.
REQ-052 Variable latency: mem_ack 5 cycles after mem_en, load -> mem_addr held constant for 5 cycles; single d_ready pulse; err=0.
REQ-053 Timeout: TMO=15, mem_ack never asserted -> after 15 BUSY cycles d_ready=1, d_rdata=0xFFFFFFFF, err=1 and stays 1.
REQ-054 Reset mid-access: rst_n=0 during the 3rd BUSY cycle -> mem_en=0 asynchronously, state IDLE, no ready pulse after release.
REQ-055 Spurious ack: mem_ack=1 in IDLE and in RESP -> no state change, no ready pulse, rdata registers unchanged.
